// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: single-stage bitwise logic unit with accumulator, valid/ready handshake and saturating op counter
module logic_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       control,
  input  logic             acc_sel,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_res;
  logic             w_accept;
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  // a clear coinciding with an accept takes effect before the operation
  assign w_a = acc_sel ? (acc_clr ? '0 : r_acc) : opA;
  always_comb begin
    w_res = '0;
    case (control)
      3'b000: w_res = w_a & opB;
      3'b001: w_res = ~(w_a & opB);
      3'b010: w_res = w_a | opB;
      3'b011: w_res = ~(w_a | opB);
      3'b100: w_res = w_a ^ opB;
      3'b101: w_res = ~(w_a ^ opB);
      3'b110: w_res = ~w_a;
      default: w_res = ~opB;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
      r_acc     <= '0;
      op_count  <= '0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      result    <= w_res;
      zero      <= ~|w_res;
      parity    <= ^w_res;
      r_acc     <= w_res;
      op_count  <= &op_count ? op_count : op_count + 1'b1;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (acc_clr) r_acc <= '0;
    end
  end
endmodule
